// File: rtl/gpr_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpr_writeback_pkg
// Purpose  : Shared widths, starvation default and the writeback entry type.
// Revision : 1.0 - initial release
// ============================================================================
package gpr_writeback_pkg;

  localparam int c_DATA_WIDTH    = 32;
  localparam int c_RF_ADDR_WIDTH = 5;
  localparam int c_STARVE_LIMIT  = 3;

  typedef struct packed {
    logic                       valid;
    logic [c_RF_ADDR_WIDTH-1:0] rd;
    logic [c_DATA_WIDTH-1:0]    value;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/gpr_wb_skid.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_skid
// Purpose  : One-entry result buffer; frees its slot in the cycle it is drained.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_skid
  import gpr_writeback_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [c_RF_ADDR_WIDTH-1:0] rd_i,
  input  logic [c_DATA_WIDTH-1:0]    val_i,
  input  logic                       sel_i,
  output wb_entry_t                  entry_o
);

  wb_entry_t entry_q, entry_d;

  // Ready looks only at buffer state and the arbiter grant, never at valid_i.
  assign ready_o = !rst_i && (!entry_q.valid || sel_i);
  assign entry_o = entry_q;

  always_comb begin
    entry_d = entry_q;
    if (valid_i && ready_o) begin
      entry_d.valid = 1'b1;
      entry_d.rd    = rd_i;
      entry_d.value = val_i;
    end else if (sel_i) begin
      entry_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpr_writeback.sv
`default_nettype none
// ============================================================================
// Module   : gpr_writeback
// Purpose  : ALU/LSU writeback arbiter with GPR pending scoreboard and hazard
//            stall. Optional forwarding is enabled by macro GPR_WB_FORWARD_EN.
//            DataWidth/RfAddrWidth must match the package entry widths.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_writeback
  import gpr_writeback_pkg::*;
#(
  parameter int DataWidth   = c_DATA_WIDTH,
  parameter int RfAddrWidth = c_RF_ADDR_WIDTH,
  parameter int NbGpr       = 32,
  parameter int StarveLimit = c_STARVE_LIMIT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   alu_valid_i,
  output logic                   alu_ready_o,
  input  logic [RfAddrWidth-1:0] alu_rd_i,
  input  logic [DataWidth-1:0]   alu_val_i,
  input  logic                   lsu_valid_i,
  output logic                   lsu_ready_o,
  input  logic [RfAddrWidth-1:0] lsu_rd_i,
  input  logic [DataWidth-1:0]   lsu_val_i,
  input  logic                   issue_valid_i,
  input  logic [RfAddrWidth-1:0] issue_rd_i,
  input  logic [RfAddrWidth-1:0] rs1_i,
  input  logic [RfAddrWidth-1:0] rs2_i,
  output logic                   stall_o,
  output logic [RfAddrWidth-1:0] rd_o,
  output logic [DataWidth-1:0]   rd_val_o,
  output logic                   rd_valid_o,
  output logic                   rs1_fwd_valid_o,
  output logic [DataWidth-1:0]   rs1_fwd_val_o,
  output logic                   rs2_fwd_valid_o,
  output logic [DataWidth-1:0]   rs2_fwd_val_o
);

  localparam int CntWidth = $clog2(StarveLimit + 2);
  localparam logic [CntWidth-1:0] StarveMax = CntWidth'(StarveLimit);

  wb_entry_t             alu_e, lsu_e;
  wb_entry_t             out_q, out_d;
  logic                  alu_sel, lsu_sel;
  logic [CntWidth-1:0]   starve_q, starve_d;
  logic [NbGpr-1:0]      pending_q, pending_d;
  logic                  w_hit_rs1, w_hit_rs2, w_hit_issue;

  function automatic logic pend_at(input logic [NbGpr-1:0] vec,
                                   input logic [RfAddrWidth-1:0] idx);
    pend_at = 1'b0;
    for (int i = 0; i < NbGpr; i++) begin
      if (idx == RfAddrWidth'(i)) pend_at = vec[i];
    end
  endfunction

  gpr_wb_skid u_alu_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (alu_valid_i),
    .ready_o (alu_ready_o),
    .rd_i    (alu_rd_i),
    .val_i   (alu_val_i),
    .sel_i   (alu_sel),
    .entry_o (alu_e)
  );

  gpr_wb_skid u_lsu_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (lsu_valid_i),
    .ready_o (lsu_ready_o),
    .rd_i    (lsu_rd_i),
    .val_i   (lsu_val_i),
    .sel_i   (lsu_sel),
    .entry_o (lsu_e)
  );

  // LSU normally wins; a starved ALU takes the slot once the counter saturates.
  always_comb begin
    alu_sel  = alu_e.valid && (!lsu_e.valid || starve_q == StarveMax);
    lsu_sel  = lsu_e.valid && !alu_sel;
    starve_d = '0;
    if (alu_e.valid && !alu_sel) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end
    out_d       = out_q;
    out_d.valid = 1'b0;
    if (alu_sel) begin
      out_d       = alu_e;
      out_d.valid = (alu_e.rd != '0);
    end else if (lsu_sel) begin
      out_d       = lsu_e;
      out_d.valid = (lsu_e.rd != '0);
    end
  end

  // Set beats clear on the same index, so a re-issue during writeback stays pending.
  always_comb begin
    pending_d = '0;
    for (int i = 1; i < NbGpr; i++) begin
      pending_d[i] = (pending_q[i] && !(rd_valid_o && rd_o == RfAddrWidth'(i)))
                   || (issue_valid_i && issue_rd_i == RfAddrWidth'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q     <= '0;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      out_q     <= out_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  assign rd_valid_o = out_q.valid && !rst_i;
  assign rd_o       = out_q.rd;
  assign rd_val_o   = out_q.value;

`ifdef GPR_WB_FORWARD_EN
  assign rs1_fwd_valid_o = rd_valid_o && (rd_o == rs1_i) && (rs1_i != '0);
  assign rs2_fwd_valid_o = rd_valid_o && (rd_o == rs2_i) && (rs2_i != '0);
  assign rs1_fwd_val_o   = rs1_fwd_valid_o ? rd_val_o : '0;
  assign rs2_fwd_val_o   = rs2_fwd_valid_o ? rd_val_o : '0;
`else
  assign rs1_fwd_valid_o = 1'b0;
  assign rs2_fwd_valid_o = 1'b0;
  assign rs1_fwd_val_o   = '0;
  assign rs2_fwd_val_o   = '0;
`endif

  assign w_hit_rs1   = pend_at(pending_q, rs1_i);
  assign w_hit_rs2   = pend_at(pending_q, rs2_i);
  assign w_hit_issue = pend_at(pending_q, issue_rd_i);

  assign stall_o = !rst_i && ((w_hit_rs1 && !rs1_fwd_valid_o)
                           || (w_hit_rs2 && !rs2_fwd_valid_o)
                           || (issue_valid_i && w_hit_issue));

`ifdef SIM
  always_ff @(posedge clk_i) begin
    if (!rst_i && rd_valid_o) begin
      assert (pend_at(pending_q, rd_o))
        else $error("writeback to non-pending GPR %0d", rd_o);
    end
  end
`endif

endmodule
`default_nettype wire
